// File: rtl/nonoverlap_mealy_fsm.sv
`default_nettype none
// ============================================================================
// Module      : nonoverlap_mealy_fsm
// Description : Mealy detector for serial pattern 1011, non-overlapping.
//               Define NONOVERLAP_MEALY_FSM_CNT_EN to add a saturating
//               detection counter on det_count.
// Revision    : 1.0 - initial release
// ============================================================================
module nonoverlap_mealy_fsm #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    output logic             out
`ifdef NONOVERLAP_MEALY_FSM_CNT_EN
    ,
    output logic [CNT_W-1:0] det_count
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   w_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S0;
        w_hit   = 1'b0;
        case (state_q)
            S0: state_d = in ? S1 : S0;
            S1: state_d = in ? S1 : S2;
            S2: state_d = in ? S3 : S0;
            S3: begin
                // A completed match restarts from idle; a 0 keeps the "10" suffix.
                if (in) begin
                    state_d = S0;
                    w_hit   = 1'b1;
                end else begin
                    state_d = S2;
                end
            end
            default: state_d = S0;
        endcase
    end

    assign out = w_hit & ~reset;

`ifdef NONOVERLAP_MEALY_FSM_CNT_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign det_count = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nonoverlap_mealy_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonoverlap_mealy_fsm
// Description : Self-checking bench for nonoverlap_mealy_fsm (CNT_W = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonoverlap_mealy_fsm;

    localparam int C_CNT_W   = 2;
    localparam int C_CNT_MAX = (1 << C_CNT_W) - 1;

    logic clk;
    logic reset_s;
    logic in_s;
    logic out_s;
`ifdef NONOVERLAP_MEALY_FSM_CNT_EN
    logic [C_CNT_W-1:0] det_count_s;
`endif

    int tests;
    int fails;

    // Reference: bits seen since the last restart and detections since reset.
    logic [2:0] m_hist;
    int         m_n;
    int         m_cnt;

    nonoverlap_mealy_fsm #(.CNT_W(C_CNT_W)) dut (
        .clk       (clk),
        .reset     (reset_s),
        .in        (in_s),
        .out       (out_s)
`ifdef NONOVERLAP_MEALY_FSM_CNT_EN
        ,
        .det_count (det_count_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // One clock of stimulus: drive, check out mid-cycle, advance model, check counter.
    task automatic step(input logic b, input logic r, output logic exp_o);
        @(negedge clk);
        in_s    = b;
        reset_s = r;
        #1;
        exp_o = !r && (m_n >= 3) && (m_hist == 3'b101) && b;
        check("out", {7'd0, out_s}, {7'd0, exp_o});
        if (r) begin
            m_hist = 3'b000;
            m_n    = 0;
            m_cnt  = 0;
        end else if (exp_o) begin
            m_hist = 3'b000;
            m_n    = 0;
            if (m_cnt < C_CNT_MAX) m_cnt++;
        end else begin
            m_hist = {m_hist[1:0], b};
            m_n    = m_n + 1;
        end
`ifdef NONOVERLAP_MEALY_FSM_CNT_EN
        @(posedge clk);
        #1;
        check("det_count", {6'd0, det_count_s}, m_cnt[7:0]);
`endif
    endtask

    // Directed sequence, MSB first; mask marks the cycles that must pulse.
    task automatic run_seq(input string tag, input logic [15:0] bits,
                           input logic [15:0] mask, input int len);
        logic e;
        for (int i = 0; i < len; i++) begin
            step(bits[len-1-i], 1'b0, e);
            check(tag, {7'd0, e}, {7'd0, mask[len-1-i]});
        end
    endtask

    task automatic do_reset(input int cycles);
        logic e;
        for (int i = 0; i < cycles; i++) begin
            step(1'b1, 1'b1, e);
            check("reset_out", {7'd0, out_s}, 8'd0);
        end
    endtask

    initial begin
        logic e;
        tests   = 0;
        fails   = 0;
        m_hist  = 3'b000;
        m_n     = 0;
        m_cnt   = 0;
        in_s    = 1'b1;
        reset_s = 1'b1;

        do_reset(2);
        run_seq("seq_0100_1011_0100", 16'b0100_1011_0100, 16'b0000_0001_0000, 12);

        do_reset(1);
        run_seq("nonoverlap", 16'b1011011, 16'b0001000, 7);

        do_reset(1);
        run_seq("fallback_101011", 16'b101011, 16'b000001, 6);

        do_reset(1);
        run_seq("fallback_111011", 16'b111011, 16'b000001, 6);

        // Reset mid-pattern while in=1 in S3: must not pulse or count.
        do_reset(1);
        run_seq("mid_pre", 16'b101, 16'b000, 3);
        do_reset(1);
        run_seq("mid_post", 16'b1011, 16'b0001, 4);

`ifdef NONOVERLAP_MEALY_FSM_CNT_EN
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            int exp_cnt;
            run_seq("cnt_pat", 16'b1011, 16'b0001, 4);
            exp_cnt = (k + 1 > 3) ? 3 : k + 1;
            check("cnt_sat", {6'd0, det_count_s}, exp_cnt[7:0]);
        end
`endif

        // Random traffic, biased toward 1s, with occasional resets.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 63) == 0), e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
